// File: rtl/project_scheduler.sv
`timescale 1ns/1ps
// project_scheduler: feeds whole triangles vertex-by-vertex into a fixed-latency projector and
// reassembles the returned points into a credit-protected output FIFO. Optional culling: PROJECT_NEAR_CULL_EN.
module project_scheduler #(
   parameter int PROJ_LATENCY = 21,
   parameter int BUF_DEPTH    = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tri_in_valid,
   output logic         tri_in_ready,
   input  logic [143:0] tri_in,
   output logic         proj_valid,
   output logic [47:0]  proj_vertex,
   input  logic         proj_pt_valid,
   input  logic [31:0]  proj_pt,
   output logic         tri_out_valid,
   input  logic         tri_out_ready,
   output logic [95:0]  tri_out,
   output logic [15:0]  cull_count,
   output logic         err,
   output logic         busy
);

   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int DW = $clog2(PROJ_LATENCY + 1);

   localparam logic [2:0] ST_DRAIN  = 3'd0;
   localparam logic [2:0] ST_IDLE   = 3'd1;
   localparam logic [2:0] ST_ISSUE0 = 3'd2;
   localparam logic [2:0] ST_ISSUE1 = 3'd3;
   localparam logic [2:0] ST_ISSUE2 = 3'd4;

   logic [2:0]    state, state_nxt;
   logic [DW-1:0] drain_cnt;
   logic [CW-1:0] credits;
   logic [CW-1:0] fifo_cnt;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [95:0]   tri_lat;
   logic [6:0]    outstanding;
   logic [1:0]    ret_idx;
   logic [31:0]   slot0, slot1;
   logic [95:0]   fifo_mem [BUF_DEPTH];

   logic          accept, cull_hit, issue_acc, pop;
   logic          pt_take, pt_err, push_req, push, push_drop, fifo_full;
   logic          vld_nxt;
   logic [47:0]   vtx_nxt;
   logic [95:0]   push_data;

   assign tri_in_ready  = (credits != '0) && (state == ST_IDLE || state == ST_ISSUE2);
   assign accept        = tri_in_valid && tri_in_ready;
   assign issue_acc     = accept && !cull_hit;
   assign tri_out_valid = (fifo_cnt != '0);
   assign tri_out       = fifo_mem[rd_ptr];
   assign pop           = tri_out_valid && tri_out_ready;
   assign fifo_full     = (fifo_cnt == CW'(BUF_DEPTH));

   // Results arriving while draining belong to work issued before reset and are dropped silently.
   assign pt_take   = proj_pt_valid && (state != ST_DRAIN) && (outstanding != '0);
   assign pt_err    = proj_pt_valid && (state != ST_DRAIN) && (outstanding == '0);
   assign push_req  = pt_take && (ret_idx == 2'd2);
   assign push      = push_req && !fifo_full && rst;
   assign push_drop = push_req && fifo_full;
   assign push_data = {proj_pt, slot1, slot0};

   assign busy = (state != ST_IDLE) || (outstanding != '0) || (fifo_cnt != '0);

`ifdef PROJECT_NEAR_CULL_EN
   // A vertex with positive z lies behind the camera.
   always_comb begin
      cull_hit = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (!tri_in[48*k+47] && (tri_in[48*k+32 +: 15] != '0)) cull_hit = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) cull_count <= '0;
      else if (accept && cull_hit && cull_count != 16'hFFFF) cull_count <= cull_count + 16'd1;
   end
`else
   assign cull_hit   = 1'b0;
   assign cull_count = '0;
`endif

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_DRAIN:  if (drain_cnt <= DW'(1)) state_nxt = ST_IDLE;
         ST_IDLE:   if (issue_acc) state_nxt = ST_ISSUE0;
         ST_ISSUE0: state_nxt = ST_ISSUE1;
         ST_ISSUE1: state_nxt = ST_ISSUE2;
         ST_ISSUE2: state_nxt = issue_acc ? ST_ISSUE0 : ST_IDLE;
         default:   state_nxt = ST_DRAIN;
      endcase

      vld_nxt = 1'b0;
      vtx_nxt = '0;
      case (state_nxt)
         ST_ISSUE0: begin vld_nxt = 1'b1; vtx_nxt = tri_in[47:0];   end
         ST_ISSUE1: begin vld_nxt = 1'b1; vtx_nxt = tri_lat[47:0];  end
         ST_ISSUE2: begin vld_nxt = 1'b1; vtx_nxt = tri_lat[95:48]; end
         default:   begin vld_nxt = 1'b0; vtx_nxt = '0;             end
      endcase
   end

   // NOTE: state registers use non-blocking assignments; reset is synchronous and active-low.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ST_DRAIN;
         drain_cnt   <= DW'(PROJ_LATENCY);
         credits     <= CW'(BUF_DEPTH);
         fifo_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         tri_lat     <= '0;
         outstanding <= '0;
         ret_idx     <= '0;
         slot0       <= '0;
         slot1       <= '0;
         proj_valid  <= 1'b0;
         proj_vertex <= '0;
         err         <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;

         if (issue_acc) tri_lat <= tri_in[143:48];
         proj_valid  <= vld_nxt;
         proj_vertex <= vtx_nxt;

         credits     <= credits + CW'(pop) - CW'(issue_acc);
         outstanding <= outstanding + 7'(proj_valid) - 7'(pt_take);

         if (pt_take) begin
            case (ret_idx)
               2'd0:    begin slot0 <= proj_pt; ret_idx <= 2'd1; end
               2'd1:    begin slot1 <= proj_pt; ret_idx <= 2'd2; end
               default: ret_idx <= 2'd0;
            endcase
         end

         if (push) wr_ptr <= (wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);

         if (pt_err || push_drop) err <= 1'b1;
      end
   end

   // NOTE: the FIFO storage is not reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= push_data;
   end

endmodule
